// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
// Includes the state encoding, the reset-cause codes and the delay counter width.
package reset_sequencer_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10,
    ST_ASSERT  = 2'b11
  } state_t;

  localparam logic [1:0] CAUSE_EXT = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

endpackage

// File: rtl/reset_sequencer_rst_sync.sv
// Reset-deassertion synchronizer: a SYNC_STAGES-deep flop chain with async active-high clear.
// The chain shifts in 1s, so sync_out rises SYNC_STAGES edges after rst goes low.
module reset_sequencer_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced release of NUM_STAGES reset domains, with software reset and reset-cause record.
// Optional watchdog is enabled by defining RESET_SEQUENCER_WDT_EN (adds wdt_kick, WDT_TIMEOUT).
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int SYNC_STAGES = 2
`ifdef RESET_SEQUENCER_WDT_EN
  , parameter int WDT_TIMEOUT = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic                  seq_hold,
`ifdef RESET_SEQUENCER_WDT_EN
  input  logic                  wdt_kick,
`endif
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  sys_ready,
  output logic [1:0]            rst_cause
);

  localparam logic [CNT_W-1:0]      DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [2:0]            IDX_LAST   = 3'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE  = NUM_STAGES'(1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stg_d;
  logic                    rdy_d;
  logic [1:0]              cause_d;
  logic                    sync_done;
  logic                    wdt_fire;

  reset_sequencer_rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk     (clk),
    .rst     (rst),
    .sync_out(sync_done)
  );

`ifdef RESET_SEQUENCER_WDT_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_TIMEOUT - 1);
  logic [15:0] wdt_q, wdt_d;

  assign wdt_fire = (state_q == ST_RUN) && (wdt_q == WDT_LAST);

  always_comb begin
    wdt_d = wdt_q + 16'd1;
    if (state_q != ST_RUN || state_d != ST_RUN || wdt_kick) wdt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdt_q <= '0;
    else     wdt_q <= wdt_d;
  end
`else
  assign wdt_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stg_d   = stage_rst_n;
    rdy_d   = sys_ready;
    cause_d = rst_cause;
    case (state_q)
      ST_SYNC: begin
        // The exit cycle already counts toward the first gap, so the counter starts at 1.
        if (sync_done) begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_W'(1);
          idx_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (!seq_hold) begin
          if (cnt_q == DELAY_LAST) begin
            cnt_d = '0;
            stg_d = stage_rst_n | (STAGE_ONE << idx_q);
            idx_d = idx_q + 3'd1;
            if (idx_q == IDX_LAST) begin
              rdy_d   = 1'b1;
              state_d = ST_RUN;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        // A software request outranks a simultaneous watchdog expiry.
        if (sw_rst_req || wdt_fire) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          stg_d   = '0;
          rdy_d   = 1'b0;
          cause_d = sw_rst_req ? CAUSE_SW : CAUSE_WDT;
        end
      end
      ST_ASSERT: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        stg_d   = '0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_n <= '0;
      sys_ready   <= 1'b0;
      rst_cause   <= CAUSE_EXT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst_n <= stg_d;
      sys_ready   <= rdy_d;
      rst_cause   <= cause_d;
    end
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Consumer end of the board-level clock/reset generation. Takes the single system clock and the asynchronous active-high system reset, synchronizes reset deassertion, and releases NUM_STAGES downstream reset domains in a fixed order with a programmable gap between releases. It also accepts a software reset request that re-runs the full sequence, and records the cause of the last reset for firmware.

Parameters:
NUM_STAGES, 4, number of sequenced reset outputs (1..8); stage 0 is released first.
STAGE_DELAY, 16, clock cycles between consecutive stage releases (2..255); also the software-reset hold time.
SYNC_STAGES, 2, depth of the reset-deassertion synchronizer (2..4).

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  asynchronous, active-high reset.
sw_rst_req  input  1  software reset request; sampled only in RUN.
seq_hold  input  1  while high in RELEASE, the delay counter freezes.
stage_rst_n  output  NUM_STAGES  active-low resets to downstream domains.
sys_ready  output  1  high when all stages are released.
rst_cause  output  2  last reset cause: 00 external rst, 01 software, 10 watchdog, 11 reserved.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. Assertion of rst acts immediately on every register, with no clock needed. Deassertion is synchronized internally.
- On rst high:
  - stage_rst_n = all 0.
  - sys_ready = 0.
  - rst_cause = 00.
  - State = SYNC, counter = 0, synchronizer chain cleared.
- Synchronizer: a SYNC_STAGES-deep shift register. It is cleared by rst and shifts in 1s.
- State SYNC: exits to RELEASE when the chain output is 1. This happens SYNC_STAGES rising edges after rst is low at an edge.
- State RELEASE:
  - An 8-bit counter increments each cycle unless seq_hold = 1.
  - When counter == STAGE_DELAY-1: on that edge, the next unreleased stage_rst_n bit is set, the counter returns to 0, and the stage index increments.
  - Stage k is released at edge SYNC_STAGES + (k+1)*STAGE_DELAY, counted from the first edge with rst low, when seq_hold stays 0.
- Last stage released: sys_ready goes to 1 on the same edge, and the state moves to RUN.
- State RUN: outputs are stable. If sw_rst_req = 1 at edge E:
  - At E, stage_rst_n becomes all 0, sys_ready = 0, rst_cause = 01.
  - State moves to ASSERT with counter = 0.
- State ASSERT: counts STAGE_DELAY cycles (seq_hold is ignored here), then enters RELEASE with stage index 0. Stage 0 is released at E + 2*STAGE_DELAY.
- sw_rst_req is ignored in SYNC, ASSERT and RELEASE; no request is queued.
- Releases are strictly in order. A stage never re-asserts except through ASSERT or rst.
- rst asserted mid-sequence or in RUN: immediate return to the reset values above. rst_cause is overwritten to 00.
- Illegal state encoding: recover to ASSERT with cause unchanged.

Optional Feature:
Macro RESET_SEQUENCER_WDT_EN.
- When defined:
  - Adds input wdt_kick (1 bit) and parameter WDT_TIMEOUT (default 1024). A 16-bit watchdog counter runs only in RUN and is cleared by wdt_kick, by leaving RUN, and by rst.
  - At counter == WDT_TIMEOUT-1 the block behaves like a software reset, but sets rst_cause = 10.
  - Simultaneous wdt expiry and sw_rst_req: the software request wins, so cause = 01.
- When undefined: no wdt_kick port, no counter, and cause 10 is never produced.

Decomposition:
- Package reset_sequencer_pkg:
  - state encoding SYNC/RELEASE/RUN/ASSERT (2-bit);
  - cause constants CAUSE_EXT = 2'b00, CAUSE_SW = 2'b01, CAUSE_WDT = 2'b10;
  - counter width constant = 8.
- One sub-module, rst_sync: a SYNC_STAGES flop chain with async active-high clear. It is reusable for other domains.

Test Plan:
- Power-on (defaults): rst high for 5 cycles, then low → stage_rst_n bits 0..3 rise at edges 18, 34, 50 and 66. sys_ready rises at edge 66, rst_cause = 00.
- Software reset: in RUN, pulse sw_rst_req for 1 cycle at edge E → stage_rst_n = 0000 and sys_ready = 0 at E. rst_cause = 01. Stage 0 is released at E+32 and sys_ready at E+80.
- Hold: seq_hold high for 10 cycles during the stage 1 gap → stage 1 and all later releases shift by exactly 10 cycles. A request inside the sequence is ignored.
- Async reset mid-sequence: rst pulsed between clock edges after stage 1 release → all outputs go to 0 immediately with no edge, and the sequence then restarts from the first bullet's timing.
- Watchdog (RESET_SEQUENCER_WDT_EN, WDT_TIMEOUT = 100): no kicks in RUN → reset at RUN entry + 100 cycles, rst_cause = 10. With kicks every 50 cycles, no reset occurs.
- Simultaneous: wdt expiry and sw_rst_req on the same edge → rst_cause = 01, single sequence restart.
